// File: rtl/img_cap_pkg.sv
// Shared types and constants for the image capture path.
package img_cap_pkg;

    // Frame-buffer arbiter states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_CMD   = 2'd2,
        S_BURST = 2'd3
    } state_t;

    // Polarity constants for active-high and active-low control signals
    localparam logic ASSERT_H   = 1'b1;
    localparam logic DEASSERT_H = 1'b0;
    localparam logic ASSERT_L   = 1'b0;
    localparam logic DEASSERT_L = 1'b1;

    // Default frame geometry (640x480 words, 64-word bursts)
    localparam int unsigned DEF_FRAME_WORDS = 307200;
    localparam int unsigned DEF_BURST_LEN   = 64;

    // Free space in a FIFO of 2**aw entries whose occupancy range tops out at 2**aw-1
    function automatic int unsigned fifo_free(input int unsigned aw, input int unsigned used);
        int unsigned full_level;
        full_level = (32'd1 << aw) - 32'd1;
        return (used > full_level) ? 32'd0 : (full_level - used);
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Per-side burst offset generator: steps one burst per completed transfer
// and wraps to zero at the end of a frame.
module fb_addr_gen
    import img_cap_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int unsigned BURST_LEN   = DEF_BURST_LEN,
    parameter int unsigned OFF_W       = $clog2(FRAME_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [OFF_W-1:0] offset,
    output logic             frame_end
);

    localparam logic [OFF_W:0] STEP  = (OFF_W+1)'(BURST_LEN);
    localparam logic [OFF_W:0] LIMIT = (OFF_W+1)'(FRAME_WORDS);

    logic [OFF_W:0] next_sum;

    // One extra bit so the sum can reach FRAME_WORDS even when it is a power of two;
    // frame_end is coincident with advance so the owner can act in the same cycle
    always_comb begin
        next_sum  = {1'b0, offset} + STEP;
        frame_end = advance && (next_sum == LIMIT);
    end

    // Offset register: cleared on reset/clear, stepped or wrapped on advance
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            offset <= '0;
        end else if (advance) begin
            offset <= frame_end ? '0 : next_sum[OFF_W-1:0];
        end
    end

endmodule

// File: rtl/fb_pingpong_arb.sv
// Frame-buffer arbiter: time-multiplexes camera write bursts and HDMI read
// bursts onto a single-port memory and owns the ping-pong buffer selection.
module fb_pingpong_arb
    import img_cap_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 24,
    parameter int unsigned       FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int unsigned       BURST_LEN   = DEF_BURST_LEN,
    parameter int unsigned       FIFO_AW     = 9,
    parameter logic [ADDR_W-1:0] FB1_BASE    = 24'h080000,
    parameter int unsigned       LOW_WATER   = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [FIFO_AW-1:0] cam_rdusedw,
    input  logic [FIFO_AW-1:0] adv_wrusedw,
    output logic              mem_cmd_valid,
    input  logic              mem_cmd_ready,
    output logic              mem_cmd_wr,
    output logic [ADDR_W-1:0] mem_cmd_addr,
    input  logic              mem_done,
    output logic              wr_fb,
    output logic              rd_fb,
    output logic              frame_repeat,
    output logic              busy
);

    localparam int unsigned OFF_W = $clog2(FRAME_WORDS);

    state_t            state;
    logic              wr_hold;
    logic [OFF_W-1:0]  wr_off;
    logic [OFF_W-1:0]  rd_off;
    logic              wr_end;
    logic              rd_end;
    logic              wr_adv;
    logic              rd_adv;
    logic              off_clear;
    logic              wr_elig;
    logic              rd_elig;
    logic              rd_urgent;
    logic              grant;
    logic              grant_wr;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    // Eligibility, priority and candidate burst addresses for both sides
    always_comb begin
        wr_elig   = (32'(cam_rdusedw) >= BURST_LEN) && !wr_hold;
        rd_elig   = fifo_free(FIFO_AW, 32'(adv_wrusedw)) >= BURST_LEN;
        rd_urgent = 32'(adv_wrusedw) < LOW_WATER;
        grant     = wr_elig || rd_elig;
        grant_wr  = wr_elig && !(rd_urgent && rd_elig);
        wr_addr   = (wr_fb ? FB1_BASE : '0) + ADDR_W'(wr_off);
        rd_addr   = (rd_fb ? FB1_BASE : '0) + ADDR_W'(rd_off);
    end

    // Offsets step only on a completion seen while a burst is outstanding
    always_comb begin
        wr_adv    = (state == S_BURST) && mem_done && mem_cmd_wr;
        rd_adv    = (state == S_BURST) && mem_done && !mem_cmd_wr;
        off_clear = (state == S_IDLE);
    end

    fb_addr_gen #(
        .FRAME_WORDS (FRAME_WORDS),
        .BURST_LEN   (BURST_LEN),
        .OFF_W       (OFF_W)
    ) u_wr_addr (
        .clk       (clk),
        .reset     (reset),
        .clear     (off_clear),
        .advance   (wr_adv),
        .offset    (wr_off),
        .frame_end (wr_end)
    );

    fb_addr_gen #(
        .FRAME_WORDS (FRAME_WORDS),
        .BURST_LEN   (BURST_LEN),
        .OFF_W       (OFF_W)
    ) u_rd_addr (
        .clk       (clk),
        .reset     (reset),
        .clear     (off_clear),
        .advance   (rd_adv),
        .offset    (rd_off),
        .frame_end (rd_end)
    );

    // Arbitration FSM with registered command, buffer-select and status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            mem_cmd_valid <= DEASSERT_H;
            mem_cmd_wr    <= 1'b0;
            mem_cmd_addr  <= '0;
            wr_fb         <= 1'b0;
            rd_fb         <= 1'b1;
            frame_repeat  <= DEASSERT_H;
            busy          <= DEASSERT_H;
            wr_hold       <= 1'b0;
        end else begin
            frame_repeat <= DEASSERT_H;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_ARB;
                    end
                end

                S_ARB: begin
                    if (!enable) begin
                        state   <= S_IDLE;
                        wr_hold <= 1'b0;
                        wr_fb   <= 1'b0;
                        rd_fb   <= 1'b1;
                    end else if (grant) begin
                        state         <= S_CMD;
                        mem_cmd_valid <= ASSERT_H;
                        mem_cmd_wr    <= grant_wr;
                        mem_cmd_addr  <= grant_wr ? wr_addr : rd_addr;
                        busy          <= ASSERT_H;
                    end
                end

                S_CMD: begin
                    // A presented command is held until accepted, even if enable drops
                    if (mem_cmd_ready) begin
                        state         <= S_BURST;
                        mem_cmd_valid <= DEASSERT_H;
                    end
                end

                S_BURST: begin
                    if (mem_done) begin
                        busy <= DEASSERT_H;
                        if (wr_adv && wr_end) begin
                            wr_hold <= 1'b1;
                        end
                        if (rd_adv && rd_end) begin
                            if (wr_hold) begin
                                wr_fb   <= ~wr_fb;
                                rd_fb   <= ~rd_fb;
                                wr_hold <= 1'b0;
                            end else begin
                                frame_repeat <= ASSERT_H;
                            end
                        end
                        // Leaving for idle overrides any swap/hold decided above
                        if (enable) begin
                            state <= S_ARB;
                        end else begin
                            state   <= S_IDLE;
                            wr_hold <= 1'b0;
                            wr_fb   <= 1'b0;
                            rd_fb   <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_pingpong_arb.sv
// Directed bench for fb_pingpong_arb using a small 128-word frame.
module tb_fb_pingpong_arb;
    import img_cap_pkg::*;

    localparam logic [23:0] FB1 = 24'h080000;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [8:0]  cam_rdusedw;
    logic [8:0]  adv_wrusedw;
    logic        mem_cmd_valid;
    logic        mem_cmd_ready;
    logic        mem_cmd_wr;
    logic [23:0] mem_cmd_addr;
    logic        mem_done;
    logic        wr_fb;
    logic        rd_fb;
    logic        frame_repeat;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fb_pingpong_arb #(
        .ADDR_W      (24),
        .FRAME_WORDS (128),
        .BURST_LEN   (64),
        .FIFO_AW     (9),
        .FB1_BASE    (FB1),
        .LOW_WATER   (128)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .cam_rdusedw   (cam_rdusedw),
        .adv_wrusedw   (adv_wrusedw),
        .mem_cmd_valid (mem_cmd_valid),
        .mem_cmd_ready (mem_cmd_ready),
        .mem_cmd_wr    (mem_cmd_wr),
        .mem_cmd_addr  (mem_cmd_addr),
        .mem_done      (mem_done),
        .wr_fb         (wr_fb),
        .rd_fb         (rd_fb),
        .frame_repeat  (frame_repeat),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Wait for a command, check it, optionally stall acceptance, then complete it
    task automatic run_burst(input string tag, input logic exp_wr, input logic [23:0] exp_addr,
                             input int stall, input int drop_at);
        int waited;
        waited = 0;
        while (!mem_cmd_valid && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, "_valid"}, 32'(mem_cmd_valid), 32'd1);
        check({tag, "_wr"},    32'(mem_cmd_wr),    32'(exp_wr));
        check({tag, "_addr"},  32'(mem_cmd_addr),  32'(exp_addr));
        check({tag, "_busy"},  32'(busy),          32'd1);
        for (int i = 0; i < stall; i++) begin
            if (i == drop_at) enable = 1'b0;
            tick();
            check({tag, "_stall_valid"}, 32'(mem_cmd_valid), 32'd1);
            check({tag, "_stall_wr"},    32'(mem_cmd_wr),    32'(exp_wr));
            check({tag, "_stall_addr"},  32'(mem_cmd_addr),  32'(exp_addr));
        end
        mem_cmd_ready = 1'b1;
        tick();
        mem_cmd_ready = 1'b0;
        check({tag, "_vdrop"},     32'(mem_cmd_valid), 32'd0);
        check({tag, "_busy_mid"},  32'(busy),          32'd1);
        tick();
        tick();
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        reset         = 1'b1;
        enable        = 1'b0;
        cam_rdusedw   = '0;
        adv_wrusedw   = '0;
        mem_cmd_ready = 1'b0;
        mem_done      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("rst_valid", 32'(mem_cmd_valid), 32'd0);
        check("rst_wr",    32'(mem_cmd_wr),    32'd0);
        check("rst_addr",  32'(mem_cmd_addr),  32'd0);
        check("rst_wr_fb", 32'(wr_fb),         32'd0);
        check("rst_rd_fb", 32'(rd_fb),         32'd1);
        check("rst_frep",  32'(frame_repeat),  32'd0);
        check("rst_busy",  32'(busy),          32'd0);
        check("rst_state", 32'(dut.state),     32'(S_IDLE));

        // Nothing eligible: stay in S_ARB; a stray mem_done must not move offsets
        enable      = 1'b1;
        adv_wrusedw = 9'd500;
        tick();
        tick();
        check("arb_wait_state", 32'(dut.state),     32'(S_ARB));
        check("arb_wait_valid", 32'(mem_cmd_valid), 32'd0);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;

        // Grant latency: one cycle after an eligible S_ARB cycle
        cam_rdusedw = 9'd64;
        adv_wrusedw = 9'd300;
        tick();
        check("grant_lat", 32'(mem_cmd_valid), 32'd1);
        run_burst("w0", 1'b1, 24'd0, 0, -1);
        run_burst("w1", 1'b1, 24'd64, 0, -1);

        // Writer now holds; reads proceed on buffer 1 even with camera data ready
        run_burst("r0", 1'b0, FB1, 0, -1);
        check("r0_wr_fb", 32'(wr_fb), 32'd0);
        run_burst("r1", 1'b0, FB1 + 24'd64, 0, -1);
        check("swap_wr_fb", 32'(wr_fb),        32'd1);
        check("swap_rd_fb", 32'(rd_fb),        32'd0);
        check("swap_frep",  32'(frame_repeat), 32'd0);
        cam_rdusedw = 9'd0;
        run_burst("r2", 1'b0, 24'd0, 0, -1);

        // Urgent read beats a ready write; reader wraps without writer hold
        cam_rdusedw = 9'd64;
        adv_wrusedw = 9'd100;
        run_burst("ru", 1'b0, 24'd64, 0, -1);
        check("rep_pulse", 32'(frame_repeat), 32'd1);
        check("rep_rd_fb", 32'(rd_fb),        32'd0);
        check("rep_wr_fb", 32'(wr_fb),        32'd1);
        adv_wrusedw = 9'd300;
        tick();
        check("rep_clear", 32'(frame_repeat), 32'd0);
        run_burst("w2", 1'b1, FB1, 0, -1);
        cam_rdusedw = 9'd0;
        run_burst("r3", 1'b0, 24'd0, 0, -1);

        // Stalled acceptance with enable dropped mid-wait
        cam_rdusedw = 9'd64;
        run_burst("ws", 1'b1, FB1 + 24'd64, 10, 5);
        check("off_state", 32'(dut.state),     32'(S_IDLE));
        check("off_wr_fb", 32'(wr_fb),         32'd0);
        check("off_rd_fb", 32'(rd_fb),         32'd1);
        check("off_valid", 32'(mem_cmd_valid), 32'd0);

        // Re-enable: offsets and hold were cleared
        enable = 1'b1;
        run_burst("wre", 1'b1, 24'd0, 0, -1);

        // Reset while a burst is outstanding
        waited = 0;
        while (!mem_cmd_valid && waited < 20) begin
            tick();
            waited++;
        end
        check("mid_valid", 32'(mem_cmd_valid), 32'd1);
        mem_cmd_ready = 1'b1;
        tick();
        mem_cmd_ready = 1'b0;
        check("mid_state", 32'(dut.state), 32'(S_BURST));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_valid", 32'(mem_cmd_valid), 32'd0);
        check("mrst_busy",  32'(busy),          32'd0);
        check("mrst_wr_fb", 32'(wr_fb),         32'd0);
        check("mrst_rd_fb", 32'(rd_fb),         32'd1);
        check("mrst_state", 32'(dut.state),     32'(S_IDLE));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
